// File: rtl/fir_inverse.sv
// Recovers x from y = h*x for the fixed FIR h=[1,2,3,4], one tap per cycle, modulo 2^DATA_WIDTH.
// Optional FIR_INV_COUNT_EN adds a 16-bit count of completed output handshakes.
module fir_inverse #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic                  y_valid,
  output logic                  y_ready,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic                  x_valid,
  input  logic                  x_ready
`ifdef FIR_INV_COUNT_EN
  ,
  output logic [15:0]           x_count
`endif
);

  typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, OUT} state_t;

  state_t                         state, state_nxt;
  logic [DATA_WIDTH-1:0]          acc;
  logic [DATA_WIDTH-1:0]          tap;
  logic [2:0][DATA_WIDTH-1:0]     x_hist;
  logic                           out_hs;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (y_valid) state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = MAC3;
      MAC3:    state_nxt = OUT;
      OUT:     if (x_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    y_ready = (state == IDLE) && !rst;
    x_valid = (state == OUT);
  end

  assign x_out  = acc;
  assign out_hs = x_valid && x_ready;

  // Tap products built from shifts/adds; truncation gives the modulo arithmetic.
  always_comb begin
    tap = '0;
    unique case (state)
      MAC1:    tap = x_hist[0] << 1;
      MAC2:    tap = x_hist[1] + (x_hist[1] << 1);
      MAC3:    tap = x_hist[2] << 2;
      default: tap = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      x_hist <= '0;
    end else begin
      unique case (state)
        IDLE:              if (y_valid) acc <= y_in;
        MAC1, MAC2, MAC3:  acc <= acc - tap;
        default:           acc <= acc;
      endcase
      if (out_hs) x_hist <= {x_hist[1], x_hist[0], acc};
    end
  end

`ifdef FIR_INV_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)         x_count <= '0;
    else if (out_hs) x_count <= x_count + 16'd1;
  end
`endif

endmodule
